// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Request side is a req/ready handshake; responses come back in order on rvalid.
interface fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register.
// Only one request is ever outstanding. A response that lands while ID is stalled
// is parked in a one-entry hold buffer, so memory is never back-pressured.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_if,
    input  logic            stall_id,
    input  logic            flush_if_id,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    fetch_unit_if.master    imem,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] addr_reg, addr_next;
    logic            kill_reg, kill_next;
    logic [XLEN-1:0] hold_pc_reg, hold_pc_next;
    logic [31:0]     hold_instr_reg, hold_instr_next;
    logic            valid_reg, valid_next;
    logic [XLEN-1:0] id_pc_reg, id_pc_next;
    logic [31:0]     id_instr_reg, id_instr_next;
    logic            deliver_live;
    logic            deliver_hold;
    logic [XLEN-1:0] branch_pc;

    // Redirect targets are always word aligned.
    assign branch_pc = {branch_target[XLEN-1:2], 2'b00};

    assign imem.req    = (state_reg == REQ);
    assign imem.addr   = addr_reg;
    assign if_id_valid = valid_reg;
    assign if_id_pc    = id_pc_reg;
    assign if_id_instr = id_instr_reg;

    // Next-state logic: fetch FSM, PC/kill/hold-buffer updates, then IF/ID priority mux.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        addr_next       = addr_reg;
        kill_next       = kill_reg;
        hold_pc_next    = hold_pc_reg;
        hold_instr_next = hold_instr_reg;
        deliver_live    = 1'b0;
        deliver_hold    = 1'b0;

        case (state_reg)
            IDLE: begin
                // A redirect in IDLE only moves the PC; the fetch starts next cycle
                // so it is guaranteed to use the new address.
                if (branch_taken) begin
                    pc_next = branch_pc;
                end else if (!stall_if) begin
                    state_next = REQ;
                    addr_next  = pc_reg;
                end
            end
            REQ: begin
                // A live request is never withdrawn or re-addressed; a redirect
                // just marks its response for discard.
                if (branch_taken) begin
                    pc_next   = branch_pc;
                    kill_next = 1'b1;
                end
                if (imem.ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (branch_taken) begin
                    pc_next = branch_pc;
                    if (imem.rvalid) begin
                        // Response arriving with the redirect is dropped on the spot.
                        state_next = IDLE;
                        kill_next  = 1'b0;
                    end else begin
                        kill_next = 1'b1;
                    end
                end else if (imem.rvalid) begin
                    state_next = IDLE;
                    if (kill_reg) begin
                        kill_next = 1'b0;
                    end else begin
                        pc_next = pc_reg + XLEN'(4);
                        if (stall_id) begin
                            hold_pc_next    = addr_reg;
                            hold_instr_next = imem.rdata;
                            state_next      = HOLD;
                        end else begin
                            deliver_live = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                // The parked instruction is on the wrong path once a branch resolves.
                if (branch_taken) begin
                    pc_next         = branch_pc;
                    hold_pc_next    = {XLEN{1'b0}};
                    hold_instr_next = NOP_INSTR;
                    state_next      = IDLE;
                end else if (!stall_id) begin
                    deliver_hold = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // IF/ID: flush beats stall beats delivery; anything else is a bubble.
        valid_next    = 1'b0;
        id_pc_next    = id_pc_reg;
        id_instr_next = NOP_INSTR;
        if (flush_if_id) begin
            valid_next    = 1'b0;
            id_instr_next = NOP_INSTR;
        end else if (stall_id) begin
            valid_next    = valid_reg;
            id_instr_next = id_instr_reg;
        end else if (deliver_live) begin
            valid_next    = 1'b1;
            id_pc_next    = addr_reg;
            id_instr_next = imem.rdata;
        end else if (deliver_hold) begin
            valid_next    = 1'b1;
            id_pc_next    = hold_pc_reg;
            id_instr_next = hold_instr_reg;
        end
    end

    // State register for the FSM, PC, hold buffer and IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            addr_reg       <= RESET_PC;
            kill_reg       <= 1'b0;
            hold_pc_reg    <= {XLEN{1'b0}};
            hold_instr_reg <= NOP_INSTR;
            valid_reg      <= 1'b0;
            id_pc_reg      <= {XLEN{1'b0}};
            id_instr_reg   <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            addr_reg       <= addr_next;
            kill_reg       <= kill_next;
            hold_pc_reg    <= hold_pc_next;
            hold_instr_reg <= hold_instr_next;
            valid_reg      <= valid_next;
            id_pc_reg      <= id_pc_next;
            id_instr_reg   <= id_instr_next;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, an imem responder with programmable
// latency, and a monitor that pops expected {pc, instr} pairs on every new IF/ID load.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_if = 1'b0;
    logic        stall_id = 1'b0;
    logic        flush_if_id = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    fetch_unit_if #(.XLEN(32)) imem ();

    fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .flush_if_id   (flush_if_id),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pops   = 0;
    int   mem_lat  = 0;
    int   pend_cnt = -1;
    logic [31:0] pend_addr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int i = 0;
        while (imem.req !== 1'b1 && i < 50) begin
            tick();
            i++;
        end
        check(name, 32'(imem.req), 32'd1);
    endtask

    task automatic wait_pops(input int n, input string name);
        int i = 0;
        while (n_pops < n && i < 50) begin
            tick();
            i++;
        end
        check(name, 32'(n_pops), 32'(n));
    endtask

    // Memory image: each word is its own address xor a fixed pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_0000;
    endfunction

    // imem responder: accept seen before a posedge, answer mem_lat cycles later.
    initial begin
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            imem.rvalid = 1'b0;
            if (pend_cnt == 0) begin
                imem.rvalid = 1'b1;
                imem.rdata  = mem_word(pend_addr);
                pend_cnt    = -1;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
            end
            if (rst) begin
                pend_cnt = -1;
            end else if (imem.req && imem.ready) begin
                pend_addr = imem.addr;
                pend_cnt  = mem_lat;
            end
        end
    end

    // Monitor: every fresh IF/ID load pops the scoreboard; bubbles must carry NOP.
    initial begin
        logic stall_now;
        exp_t e;
        forever begin
            @(posedge clk);
            stall_now = stall_id;
            #1;
            if (rst) continue;
            if (if_id_valid === 1'b1) begin
                if (!stall_now) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_delivery: got pc %h instr %h, expected none",
                                 if_id_pc, if_id_instr);
                    end else begin
                        e = exp_q.pop_front();
                        n_pops++;
                        check("sb_pc", if_id_pc, e.pc);
                        check("sb_instr", if_id_instr, e.instr);
                    end
                end
            end else begin
                check("bubble_instr", if_id_instr, NOP);
            end
        end
    end

    // Directed stimulus.
    initial begin
        imem.ready = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        check("rst_req", 32'(imem.req), 32'd0);
        check("rst_addr", imem.addr, 32'h0);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_pc", if_id_pc, 32'h0);
        check("rst_instr", if_id_instr, NOP);

        // Zero-wait memory from reset: one instruction every third cycle.
        push_exp(32'h0000_0000, 32'h1357_0000);
        push_exp(32'h0000_0004, 32'h1357_0004);
        push_exp(32'h0000_0008, 32'h1357_0008);
        rst = 1'b0;
        repeat (9) tick();
        check("t1_three_in_nine_cycles", 32'(n_pops), 32'd3);
        stall_if = 1'b1;
        tick();

        // Response lands under stall_id: IF/ID keeps the bubble, buffer keeps the word.
        push_exp(32'h0000_000C, 32'h1357_000C);
        stall_id = 1'b1;
        stall_if = 1'b0;
        tick();
        stall_if = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_hold_valid", 32'(if_id_valid), 32'd0);
            check("t2_hold_pc", if_id_pc, 32'h0000_0008);
            check("t2_hold_instr", if_id_instr, NOP);
        end
        stall_id = 1'b0;
        tick();
        check("t2_release_count", 32'(n_pops), 32'd4);
        check("t2_release_instr", if_id_instr, 32'h1357_000C);

        // Branch while in WAIT: the in-flight word is dropped, fetch resumes at 0x100.
        push_exp(32'h0000_0100, 32'h1357_0100);
        mem_lat  = 2;
        stall_if = 1'b0;
        wait_req("t3_req");
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        mem_lat       = 0;
        tick();
        branch_taken = 1'b0;
        tick();
        wait_req("t3_refetch_req");
        check("t3_refetch_addr", imem.addr, 32'h0000_0100);
        stall_if = 1'b1;
        wait_pops(5, "t3_redirect_delivered");

        // ready held low with stall_if toggling: request must not move.
        imem.ready = 1'b0;
        stall_if   = 1'b0;
        push_exp(32'h0000_0104, 32'h1357_0104);
        wait_req("t4_req");
        for (int k = 0; k < 5; k++) begin
            check("t4_req_stable", 32'(imem.req), 32'd1);
            check("t4_addr_stable", imem.addr, 32'h0000_0104);
            stall_if = ~stall_if;
            tick();
        end
        imem.ready = 1'b1;
        stall_if   = 1'b1;
        wait_pops(6, "t4_delivered");

        // flush and stall_id together: flush wins.
        check("t5_pre_valid", 32'(if_id_valid), 32'd1);
        flush_if_id = 1'b1;
        stall_id    = 1'b1;
        tick();
        check("t5_flush_valid", 32'(if_id_valid), 32'd0);
        check("t5_flush_instr", if_id_instr, 32'h0000_0013);
        flush_if_id = 1'b0;
        stall_id    = 1'b0;

        // Branch to the top word (with stall_if also high), then PC wraps to 0.
        push_exp(32'hFFFF_FFFC, 32'hECA8_FFFC);
        push_exp(32'h0000_0000, 32'h1357_0000);
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        stall_if     = 1'b0;
        wait_req("t6_req_top");
        check("t6_addr_top", imem.addr, 32'hFFFF_FFFC);
        wait_pops(7, "t6_top_delivered");
        wait_req("t6_req_wrap");
        check("t6_addr_wrap", imem.addr, 32'h0000_0000);
        wait_pops(8, "t6_wrap_delivered");
        stall_if = 1'b1;
        tick();

        // Reset in the middle of a request clears everything at once.
        imem.ready = 1'b0;
        stall_if   = 1'b0;
        wait_req("t7_req");
        rst = 1'b1;
        #1;
        check("t7_rst_req", 32'(imem.req), 32'd0);
        check("t7_rst_addr", imem.addr, 32'h0);
        check("t7_rst_valid", 32'(if_id_valid), 32'd0);
        stall_if = 1'b1;
        imem.ready = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("t7_idle_after_rst", 32'(imem.req), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
